// File: rtl/alc_seq.sv
// rtl/alc_seq.sv - ALC instruction sequencer: decodes one ALC word into datapath gates and strobes
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   i_start, i_ir         one-cycle request and the 16-bit ALC instruction to execute
//   i_MX, i_YIC           latched datapath result and carry-out, sampled in the write-back cycle
//   i_DD                  multiply/divide unit busy; blocks acceptance of a new instruction
//   o_L_Mcs, o_Ln_Mjg     one-hot operand (ACS) and result (ACD) accumulator gates
//   o_Mcs_Q..o_JWF        adder input, increment and carry-base controls
//   o_Q_*MX               shifter selects
//   o_DRJG, o_DRL, o_DRCj result-latch, accumulator-write and carry-write strobes
//   o_busy, o_done, o_skip, o_err  status
//
// Every output is a flop. The next-cycle output image is computed from the next
// state, so outputs switch on the same edge as the state register and never glitch.

module alc_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [15:0] i_ir,
  input  logic [15:0] i_MX,
  input  logic        i_YIC,
  input  logic        i_DD,
  output logic [3:0]  o_L_Mcs,
  output logic [3:0]  o_Ln_Mjg,
  output logic        o_Mcs_Q,
  output logic        o_Mcsn_Q,
  output logic        o_Mjg_Q,
  output logic        o_McsMjg_Q,
  output logic        o_1_Q,
  output logic        o_JW0,
  output logic        o_JWF,
  output logic        o_Q_MX,
  output logic        o_Q_Y_MX,
  output logic        o_Q_Z_MX,
  output logic        o_Q_B_MX,
  output logic        o_DRJG,
  output logic [3:0]  o_DRL,
  output logic        o_DRCj,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_skip,
  output logic        o_err
);

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_LATCH, S_WB, S_DONE} state_t;

  typedef struct packed {
    logic [3:0] l_mcs;
    logic [3:0] ln_mjg;
    logic       mcs_q;
    logic       mcsn_q;
    logic       mjg_q;
    logic       mcsmjg_q;
    logic       one_q;
    logic       jw0;
    logic       jwf;
    logic       q_mx;
    logic       q_y_mx;
    logic       q_z_mx;
    logic       q_b_mx;
    logic       drjg;
    logic [3:0] drl;
    logic       drcj;
    logic       busy;
    logic       done;
    logic       skip;
    logic       err;
  } ctl_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q;
  ctl_t        ctl_q, ctl_d;
  logic        accept;
  logic [15:0] ir_sel;
  logic        in_op;
  logic        mx_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      if (accept) ir_q <= i_ir;
    end
  end

  always_comb begin
    accept  = (state_q == S_IDLE) && i_start && !i_DD;
    // On the accepting edge the instruction is not yet in ir_q, so decode straight from i_ir.
    ir_sel  = accept ? i_ir : ir_q;
    mx_zero = (i_MX == 16'h0000);
    state_d = state_q;
    ctl_d   = '0;

    case (state_q)
      S_IDLE:  if (accept) state_d = i_ir[15] ? S_SEL : S_DONE;
      S_SEL:   state_d = S_LATCH;
      S_LATCH: state_d = S_WB;
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    in_op = (state_d == S_SEL) || (state_d == S_LATCH) || (state_d == S_WB);

    if (in_op) begin
      ctl_d.l_mcs  = 4'b0001 << ir_sel[14:13];
      ctl_d.ln_mjg = 4'b0001 << ir_sel[12:11];
      case (ir_sel[10:8])
        3'b000: ctl_d.mcsn_q = 1'b1;
        3'b001: begin ctl_d.mcsn_q = 1'b1; ctl_d.one_q = 1'b1; end
        3'b010: ctl_d.mcs_q = 1'b1;
        3'b011: begin ctl_d.mcs_q = 1'b1; ctl_d.one_q = 1'b1; end
        3'b100: begin ctl_d.mcsn_q = 1'b1; ctl_d.mjg_q = 1'b1; end
        3'b101: begin ctl_d.mcsn_q = 1'b1; ctl_d.mjg_q = 1'b1; ctl_d.one_q = 1'b1; end
        3'b110: begin ctl_d.mcs_q = 1'b1; ctl_d.mjg_q = 1'b1; end
        default: ctl_d.mcsmjg_q = 1'b1;
      endcase
      case (ir_sel[5:4])
        2'b00: ;
        2'b01: ctl_d.jw0 = 1'b1;
        2'b10: begin ctl_d.jw0 = 1'b1; ctl_d.jwf = 1'b1; end
        default: ctl_d.jwf = 1'b1;
      endcase
      case (ir_sel[7:6])
        2'b00: ctl_d.q_mx   = 1'b1;
        2'b01: ctl_d.q_y_mx = 1'b1;
        2'b10: ctl_d.q_z_mx = 1'b1;
        default: ctl_d.q_b_mx = 1'b1;
      endcase
    end

    ctl_d.drjg = (state_d == S_LATCH);
    if ((state_d == S_WB) && !ir_sel[3]) begin
      ctl_d.drl  = 4'b0001 << ir_sel[12:11];
      ctl_d.drcj = 1'b1;
    end

    ctl_d.busy = (state_d != S_IDLE);
    ctl_d.done = (state_d == S_DONE);
    ctl_d.err  = (state_d == S_DONE) && !ir_sel[15];

    // Only the WB->DONE transition samples the datapath flags; the illegal path skips WB.
    if (state_q == S_WB) begin
      case (ir_q[2:0])
        3'b000: ctl_d.skip = 1'b0;
        3'b001: ctl_d.skip = 1'b1;
        3'b010: ctl_d.skip = !i_YIC;
        3'b011: ctl_d.skip = i_YIC;
        3'b100: ctl_d.skip = mx_zero;
        3'b101: ctl_d.skip = !mx_zero;
        3'b110: ctl_d.skip = !i_YIC || mx_zero;
        default: ctl_d.skip = i_YIC && !mx_zero;
      endcase
    end
  end

  assign o_L_Mcs    = ctl_q.l_mcs;
  assign o_Ln_Mjg   = ctl_q.ln_mjg;
  assign o_Mcs_Q    = ctl_q.mcs_q;
  assign o_Mcsn_Q   = ctl_q.mcsn_q;
  assign o_Mjg_Q    = ctl_q.mjg_q;
  assign o_McsMjg_Q = ctl_q.mcsmjg_q;
  assign o_1_Q      = ctl_q.one_q;
  assign o_JW0      = ctl_q.jw0;
  assign o_JWF      = ctl_q.jwf;
  assign o_Q_MX     = ctl_q.q_mx;
  assign o_Q_Y_MX   = ctl_q.q_y_mx;
  assign o_Q_Z_MX   = ctl_q.q_z_mx;
  assign o_Q_B_MX   = ctl_q.q_b_mx;
  assign o_DRJG     = ctl_q.drjg;
  assign o_DRL      = ctl_q.drl;
  assign o_DRCj     = ctl_q.drcj;
  assign o_busy     = ctl_q.busy;
  assign o_done     = ctl_q.done;
  assign o_skip     = ctl_q.skip;
  assign o_err      = ctl_q.err;

endmodule
